mem_access_unit: RTL

Memory-stage responder for the control decoder's memory fields. It takes MemoryRE, MemoryWE, SizeOut and Unsigned together with the ALU-computed address and the store data, and runs one byte-enabled word-bus transaction per access. It stalls the pipeline until the bus acknowledges. For loads it extracts, sign- or zero-extends, and returns the selected byte, halfword or word. It sits between the execute/memory pipeline register and the data-memory bus.

---
 rtl/mem_access_unit_pkg.sv | 22 ++
 rtl/mem_access_unit_load_extract.sv | 38 +++
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and
// the default bus timeout.
package mem_access_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   localparam int TIMEOUT_CYCLES_DEFAULT = 255;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_e;

   // The decoder may send 2'b10 for a word; fold it onto the canonical code.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return size[1] ? SIZE_WORD : size;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Big-endian lane select with sign/zero extension of a bus read word.
// Also used by the writeback bypass path.
module load_extract
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        byte_sign;
   logic        half_sign;

   always_comb begin
      byte_lane = 8'h00;
      case (addr_lo)
         2'd0:    byte_lane = rdata[31:24];
         2'd1:    byte_lane = rdata[23:16];
         2'd2:    byte_lane = rdata[15:8];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
      byte_sign = ~is_unsigned & byte_lane[7];
      half_sign = ~is_unsigned & half_lane[15];

      data = rdata;
      case (size)
         SIZE_BYTE: data = {{24{byte_sign}}, byte_lane};
         SIZE_HALF: data = {{16{half_sign}}, half_lane};
         default:   data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage responder: one byte-enabled word-bus transaction per access,
// stalling the pipeline until BusAck. Optional timeout via MEM_TIMEOUT_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        MemoryRE,
   input  logic        MemoryWE,
   input  logic [1:0]  SizeOut,
   input  logic        Unsigned,
   input  logic [31:0] Address,
   input  logic [31:0] StoreData,
   output logic        Stall,
   output logic        Done,
   output logic [31:0] LoadData,
   output logic        AlignError,
   output logic        BusError,
   output logic        BusReq,
   output logic        BusWE,
   output logic [31:0] BusAddr,
   output logic [3:0]  BusByteEn,
   output logic [31:0] BusWData,
   input  logic        BusAck,
   input  logic [31:0] BusRData
);

   state_e      state_q, state_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  byte_en_q, byte_en_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [31:0] load_data_q, load_data_d;

   logic        req;
   logic [1:0]  size_in;
   logic        misaligned;
   logic [3:0]  byte_en_in;
   logic [31:0] wdata_in;
   logic [31:0] extract_data;

`ifdef MEM_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        bus_error_q, bus_error_d;
`endif

   load_extract u_load_extract (
      .rdata       (BusRData),
      .addr_lo     (addr_lo_q),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .data        (extract_data)
   );

   always_comb begin
      req        = MemoryRE | MemoryWE;
      size_in    = norm_size(SizeOut);
      misaligned = ((size_in == SIZE_HALF) && Address[0]) ||
                   ((size_in == SIZE_WORD) && (Address[1:0] != 2'b00));
      byte_en_in = 4'b1111;
      wdata_in   = StoreData;
      case (size_in)
         SIZE_BYTE: begin
            byte_en_in = 4'b1000 >> Address[1:0];
            wdata_in   = {4{StoreData[7:0]}};
         end
         SIZE_HALF: begin
            byte_en_in = 4'b1100 >> Address[1:0];
            wdata_in   = {2{StoreData[15:0]}};
         end
         default: ;
      endcase
   end

   // Requests seen in DONE are deliberately dropped: the pipeline advances on that edge.
   always_comb begin
      state_d     = state_q;
      bus_addr_d  = bus_addr_q;
      byte_en_d   = byte_en_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      addr_lo_d   = addr_lo_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      load_data_d = load_data_q;
      Stall       = 1'b0;
      AlignError  = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d       = cnt_q;
      bus_error_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req && misaligned) begin
               AlignError = 1'b1;
            end else if (req) begin
               Stall      = 1'b1;
               state_d    = ACCESS;
               bus_addr_d = {Address[31:2], 2'b00};
               byte_en_d  = byte_en_in;
               wdata_d    = wdata_in;
               we_d       = MemoryWE;
               addr_lo_d  = Address[1:0];
               size_d     = size_in;
               unsigned_d = Unsigned;
`ifdef MEM_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         ACCESS: begin
            Stall = 1'b1;
            if (BusAck) begin
               state_d     = DONE;
               load_data_d = extract_data;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_LAST) begin
               state_d     = DONE;
               load_data_d = '0;
               bus_error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= IDLE;
         bus_addr_q  <= '0;
         byte_en_q   <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         addr_lo_q   <= '0;
         size_q      <= SIZE_BYTE;
         unsigned_q  <= 1'b0;
         load_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= '0;
         bus_error_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_addr_q  <= bus_addr_d;
         byte_en_q   <= byte_en_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         addr_lo_q   <= addr_lo_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         load_data_q <= load_data_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q       <= cnt_d;
         bus_error_q <= bus_error_d;
`endif
      end
   end

   assign Done      = (state_q == DONE);
   assign BusReq    = (state_q == ACCESS);
   assign BusWE     = we_q;
   assign BusAddr   = bus_addr_q;
   assign BusByteEn = byte_en_q;
   assign BusWData  = wdata_q;
   assign LoadData  = load_data_q;
`ifdef MEM_TIMEOUT_EN
   assign BusError  = bus_error_q;
`else
   assign BusError  = 1'b0;
`endif

endmodule
